// File: rtl/tick_counter.sv
// Prescaled up/down modulo counter with IDLE/RUN/DONE sequencing, one-shot mode,
// saturating synchronous load and registered tick/tc pulses.
//
// state | meaning
// IDLE  | stopped; q holds, prescaler cleared
// RUN   | prescaler advances on en; each prescaler terminal steps q
// DONE  | one-shot finished; q holds the wrapped value until start/stop
module tick_counter #(
  parameter int DIV_W = 28,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] mod_val,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_pre;
  logic [DIV_W-1:0] w_pre_nxt;
  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_q_adv;
  logic [CNT_W-1:0] w_load_sat;
  logic             r_tick;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;
  logic             w_tick_nxt;
  logic             w_tc_nxt;
  logic             w_wrap;
  logic             w_pre_hit;

  // >= rather than == so that lowering div_val below the running count ticks at once
  assign w_pre_hit  = (r_pre >= div_val);
  assign w_load_sat = (load_val > mod_val) ? mod_val : load_val;

  // Next count value for one tick; out-of-range q is pulled back into 0..mod_val
  always_comb begin
    w_q_adv = r_q;
    w_wrap  = 1'b0;
    if (dir) begin
      if (r_q >= mod_val) begin
        w_q_adv = '0;
        w_wrap  = 1'b1;
      end else begin
        w_q_adv = r_q + CNT_W'(1);
      end
    end else begin
      if (r_q > mod_val) begin
        w_q_adv = mod_val;
      end else if (r_q == '0) begin
        w_q_adv = mod_val;
        w_wrap  = 1'b1;
      end else begin
        w_q_adv = r_q - CNT_W'(1);
      end
    end
  end

  // Per-cycle priority: load, then stop, then start, then tick advance
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_q_nxt     = r_q;
    w_tick_nxt  = 1'b0;
    w_tc_nxt    = 1'b0;
    if (load) begin
      w_q_nxt   = w_load_sat;
      w_pre_nxt = '0;
    end else if (stop) begin
      w_pre_nxt   = '0;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_pre_nxt   = '0;
          end
        end
        S_RUN: begin
          if (en) begin
            if (w_pre_hit) begin
              w_pre_nxt  = '0;
              w_tick_nxt = 1'b1;
              w_q_nxt    = w_q_adv;
              w_tc_nxt   = w_wrap;
              if (w_wrap && oneshot) begin
                w_state_nxt = S_DONE;
              end
            end else begin
              w_pre_nxt = r_pre + DIV_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_pre_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_q     <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_q     <= w_q_nxt;
      r_tick  <= w_tick_nxt;
      r_tc    <= w_tc_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign q    = r_q;
  assign tick = r_tick;
  assign tc   = r_tc;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter: expected output vectors are queued with each
// stimulus step and compared one cycle later, just after the clock edge.
module tb_tick_counter;

  localparam int DIV_W = 28;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic [CNT_W-1:0] mod_val;
  logic             dir;
  logic             oneshot;
  logic             start;
  logic             stop;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] q;
  logic             tick;
  logic             tc;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  tick_counter #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .mod_val(mod_val),
    .dir(dir), .oneshot(oneshot), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .q(q), .tick(tick), .tc(tc), .busy(busy), .done(done)
  );

  typedef struct {
    string              tag;
    logic [CNT_W+3:0]   v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dn_seq[7] = '{5, 4, 3, 2, 1, 0, 5};

  // Vector layout: {q, tick, tc, busy, done}
  task automatic push(input string tag, input int eq, input bit etk, input bit etc,
                      input bit eby, input bit edn);
    exp_t e;
    e.tag = tag;
    e.v   = {CNT_W'(eq), etk, etc, eby, edn};
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input int eq, input bit etk, input bit etc,
                      input bit eby, input bit edn);
    exp_t             e;
    logic [CNT_W+3:0] obs;
    push(tag, eq, etk, etc, eby, edn);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {q, tick, tc, busy, done};
    n_cmp++;
    assert (obs === e.v) else begin
      n_bad++;
      $error("FAIL %s: observed q/tick/tc/busy/done=%b required %b", e.tag, obs, e.v);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; div_val = 4; mod_val = 7; dir = 1'b1; oneshot = 1'b0;
    start = 1'b1; stop = 1'b0; load = 1'b1; load_val = 5;
    step("reset_overrides", 0, 0, 0, 0, 0);
    start = 1'b0; load = 1'b0;
    step("reset_hold", 0, 0, 0, 0, 0);

    // Continuous up count, div 4 / mod 7
    rst = 1'b0; start = 1'b1;
    step("first_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 80; k++)
      step($sformatf("up_k%0d", k), (k / 5) % 8, (k % 5) == 0, (k % 40) == 0, 1, 0);
    stop = 1'b1;
    step("stop_run", 0, 0, 0, 0, 0);
    stop = 1'b0;

    // Down count every cycle, mod 5
    dir = 1'b0; div_val = 0; mod_val = 5; start = 1'b1;
    step("start_down", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int i = 0; i < 7; i++)
      step($sformatf("down_i%0d", i), dn_seq[i], 1, (i == 0) || (i == 6), 1, 0);
    rst = 1'b1;
    step("rst_mid_run", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // One-shot, armed from IDLE then re-armed from DONE
    oneshot = 1'b1; mod_val = 3; div_val = 1; dir = 1'b1;
    for (int p = 0; p < 2; p++) begin
      start = 1'b1;
      step($sformatf("os_start_p%0d", p), 0, 0, 0, 1, 0);
      start = 1'b0;
      for (int k = 1; k <= 8; k++)
        step($sformatf("os_p%0d_k%0d", p, k), (k / 2) % 4, (k % 2) == 0, k == 8, k != 8, k == 8);
      for (int h = 0; h < 3; h++)
        step($sformatf("os_hold_p%0d_h%0d", p, h), 0, 0, 0, 0, 1);
    end
    start = 1'b1; stop = 1'b1;
    step("start_stop_in_done", 0, 0, 0, 0, 0);
    stop = 1'b0;

    // Start held in RUN is ignored; load saturates and restarts the prescaler
    oneshot = 1'b0; div_val = 4; mod_val = 7;
    step("run_start", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("start_ignored_%0d", i), 0, 0, 0, 1, 0);
    start = 1'b0; mod_val = 4; load = 1'b1; load_val = 6;
    step("load_saturate", 4, 0, 0, 1, 0);
    load = 1'b0;
    for (int k = 1; k <= 5; k++)
      step($sformatf("post_load_k%0d", k), (k == 5) ? 0 : 4, k == 5, k == 5, 1, 0);

    // Freeze with en low, lower div_val below the frozen prescaler count
    div_val = 9;
    for (int i = 0; i < 6; i++)
      step($sformatf("pre_run_%0d", i), 0, 0, 0, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) div_val = 2;
      step($sformatf("frozen_%0d", i), 0, 0, 0, 1, 0);
    end
    en = 1'b1;
    step("resume_tick", 1, 1, 0, 1, 0);
    for (int k = 1; k <= 3; k++)
      step($sformatf("div2_k%0d", k), (k == 3) ? 2 : 1, k == 3, 0, 1, 0);

    // q above mod_val: up wraps with tc, down clamps without tc
    mod_val = 1; div_val = 0;
    step("up_over_mod", 0, 1, 1, 1, 0);
    step("up_to_1", 1, 1, 0, 1, 0);
    step("up_wrap_mod1", 0, 1, 1, 1, 0);
    mod_val = 7; load = 1'b1; load_val = 6;
    step("load_6", 6, 0, 0, 1, 0);
    load = 1'b0; mod_val = 3; dir = 1'b0;
    step("down_over_mod", 3, 1, 0, 1, 0);
    step("down_to_2", 2, 1, 0, 1, 0);

    // Load in IDLE leaves the state alone
    stop = 1'b1;
    step("stop_holds_q", 2, 0, 0, 0, 0);
    stop = 1'b0; load = 1'b1; load_val = 5; mod_val = 7;
    step("load_idle", 5, 0, 0, 0, 0);
    load = 1'b0;
    step("idle_hold", 5, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
